// File: rtl/and3_response_checker.sv
// Response checker for a three-input AND gate: waits for {a,b,c} to settle, checks d/e, accumulates errors and coverage.
// Optional macro AND3_CHK_STOP_ON_ERR_EN: the first mismatch ends the run immediately.
module and3_response_checker #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned NUM_CHECKS = 16,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned E_INV      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       cov,
    output logic [4:0]       first_err,
    output logic             first_err_vld
);

    typedef enum logic [2:0] {IDLE, SETTLE, CHECK, WAIT, DONE} state_t;

    localparam logic [7:0]  SETTLE_LD = 8'(SETTLE_CYC);
    localparam logic [15:0] NUM_LD    = 16'(NUM_CHECKS);

    state_t      state;
    logic [2:0]  held;
    logic [7:0]  cnt;
    logic [15:0] chk_cnt;

    logic [2:0]  live;
    logic        vec_chg;
    logic        exp_d;
    logic        exp_e;
    logic        mismatch;
    logic [15:0] chk_nxt;
    logic        stop_run;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign live     = {a, b, c};
    assign vec_chg  = (live != held);
    assign exp_d    = &held;
    assign exp_e    = (E_INV != 0) ? ~exp_d : exp_d;
    assign mismatch = (d != exp_d) || (e != exp_e);
    assign chk_nxt  = chk_cnt + 16'd1;

`ifdef AND3_CHK_STOP_ON_ERR_EN
    assign stop_run = (chk_nxt == NUM_LD) || mismatch;
`else
    assign stop_run = (chk_nxt == NUM_LD);
`endif

    // pass is decoded purely from registers so it never glitches
    assign pass = done && (err_cnt == '0) && (cov == 8'hFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            held          <= 3'b000;
            cnt           <= 8'd0;
            chk_cnt       <= 16'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_cnt       <= '0;
            cov           <= 8'h00;
            first_err     <= 5'b00000;
            first_err_vld <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_cnt       <= '0;
                        cov           <= 8'h00;
                        first_err     <= 5'b00000;
                        first_err_vld <= 1'b0;
                        chk_cnt       <= 16'd0;
                        held          <= live;
                        cnt           <= SETTLE_LD;
                        state         <= SETTLE;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                    end
                end
                SETTLE: begin
                    // any movement of the stimulus restarts the settle window
                    if (vec_chg) begin
                        held <= live;
                        cnt  <= SETTLE_LD;
                    end else if (cnt == 8'd0) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_cnt <= sat_inc(err_cnt);
                        if (!first_err_vld) begin
                            first_err     <= {held, d, e};
                            first_err_vld <= 1'b1;
                        end
                    end
                    cov[held] <= 1'b1;
                    chk_cnt   <= chk_nxt;
                    if (stop_run) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // a change made during CHECK is still visible here against held
                    if (vec_chg) begin
                        held  <= live;
                        cnt   <= SETTLE_LD;
                        state <= SETTLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and3_response_checker.sv
// Directed bench for and3_response_checker: a default instance plus a CNT_W=2, E_INV=1 instance fed a non-inverted e.
module tb_and3_response_checker;

    logic clk;
    logic rst;
    logic start;
    logic a, b, c;
    logic d_stuck;
    logic d_flip;
    logic d, e;

    logic       busy, done, pass, fev;
    logic [7:0] err_cnt, cov;
    logic [4:0] first_err;

    logic       busy2, done2, pass2, fev2;
    logic [1:0] err_cnt2;
    logic [7:0] cov2;
    logic [4:0] first_err2;

    int n_chk;
    int n_fail;

    // gate model under test: e always correct, d optionally stuck-at-0 or flipped
    assign d = d_stuck ? 1'b0 : ((a & b & c) ^ d_flip);
    assign e = a & b & c;

    and3_response_checker #(.SETTLE_CYC(2), .NUM_CHECKS(16), .CNT_W(8), .E_INV(0)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .d(d), .e(e),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .cov(cov),
        .first_err(first_err), .first_err_vld(fev)
    );

    and3_response_checker #(.SETTLE_CYC(2), .NUM_CHECKS(16), .CNT_W(2), .E_INV(1)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .d(d), .e(e),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2), .cov(cov2),
        .first_err(first_err2), .first_err_vld(fev2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // start a run on vector 000 and walk 000,001,... holding each vector 5 cycles
    task automatic walk(input int nvec, input int flip_idx);
        {a, b, c} = 3'b000;
        d_flip = (flip_idx == 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        for (int i = 1; i < nvec; i++) begin
            {a, b, c} = 3'(i);
            d_flip = (i == flip_idx);
            step(5);
        end
        d_flip = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        start = 1'b0;
        {a, b, c} = 3'b000;
        d_stuck = 1'b0;
        d_flip = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_cov", cov, 0);
        chk("rst_pass", pass, 0);
        step(2);
        rst = 1'b0;
        step(1);

        // good gate, two full walks; second instance sees every e as wrong
        walk(16, -1);
        step(2);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_err", err_cnt, 0);
        chk("t1_cov", cov, 8'hFF);
        chk("t1_pass", pass, 1);
        chk("t1_fev", fev, 0);
        chk("t5_done", done2, 1);
`ifdef AND3_CHK_STOP_ON_ERR_EN
        chk("t5_err", err_cnt2, 1);
`else
        chk("t5_err", err_cnt2, 3);
`endif
        chk("t5_first", first_err2, 5'b00000);
        chk("t5_fev", fev2, 1);
        chk("t5_pass", pass2, 0);

        // d stuck-at-0: only vector 111 disagrees
        d_stuck = 1'b1;
        walk(16, -1);
        step(2);
        d_stuck = 1'b0;
        chk("t2_done", done, 1);
`ifdef AND3_CHK_STOP_ON_ERR_EN
        chk("t2_err", err_cnt, 1);
`else
        chk("t2_err", err_cnt, 2);
`endif
        chk("t2_first", first_err, 5'b11101);
        chk("t2_fev", fev, 1);
        chk("t2_pass", pass, 0);

        // glitching stimulus: only the final stable 111 is checked
        {a, b, c} = 3'b011;
        start = 1'b1;
        step(1);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            {a, b, c} = (k % 2 == 0) ? 3'b111 : 3'b011;
            step(1);
        end
        step(3);
        chk("t3_nochk_cov", cov, 0);
        chk("t3_busy", busy, 1);
        step(1);
        chk("t3_cov", cov, 8'h80);
        chk("t3_err", err_cnt, 0);
        chk("t3_notdone", done, 0);

        // start while in WAIT must not restart the run
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        chk("ign_start_cov", cov, 8'h80);
        chk("ign_start_busy", busy, 1);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);

        // async reset in WAIT after 7 checks, then a full clean run
        walk(7, -1);
        chk("t4_pre_busy", busy, 1);
        chk("t4_pre_cov", cov, 8'h7F);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_err", err_cnt, 0);
        chk("t4_cov", cov, 0);
        step(1);
        rst = 1'b0;
        step(1);
        walk(16, -1);
        step(2);
        chk("t4_rerun_done", done, 1);
        chk("t4_rerun_pass", pass, 1);
        chk("t4_rerun_cov", cov, 8'hFF);

        // single d fault on the third vector (010)
        walk(3, 2);
`ifdef AND3_CHK_STOP_ON_ERR_EN
        chk("t6_done", done, 1);
        chk("t6_busy", busy, 0);
        chk("t6_err", err_cnt, 1);
        chk("t6_cov", cov, 8'h07);
        chk("t6_first", first_err, 5'b01010);
        chk("t6_pass", pass, 0);
`else
        chk("t6_busy", busy, 1);
        chk("t6_err", err_cnt, 1);
        chk("t6_cov", cov, 8'h07);
        chk("t6_first", first_err, 5'b01010);
        for (int i = 3; i < 16; i++) begin
            {a, b, c} = 3'(i);
            step(5);
        end
        step(2);
        chk("t6_done", done, 1);
        chk("t6_err_end", err_cnt, 1);
        chk("t6_pass", pass, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
